load_buffer: RTL and testbench
==============================

# load_buffer

Load execution unit of the out-of-order core. Accepts address-resolved loads from the address unit into an in-order FIFO, issues one memory read at a time to the memory controller, size-extends the returned data and broadcasts it on the load-buffer CDB lane (tag + result) consumed by the reservation station and reorder buffer. It drives the load-ready signal that the reservation station samples before releasing a load.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- PTR_WIDTH, 2, log2(DEPTH)

- clk_in  input  1  clock, all state on posedge
- rst_in  input  1  reset, asynchronous, active-high
- rdy_in  input  1  global enable; low freezes all state and registered outputs
- rob_lbuffer_rst_in  input  1  misprediction flush, synchronous, sampled when rdy_in high
- addrunit_lbuffer_en_in  input  1  enqueue request
- addrunit_lbuffer_addr_in  input  `AddressWidth  effective address
- addrunit_lbuffer_dest_in  input  `ROBWidth  destination ROB tag, never 0
- addrunit_lbuffer_opcode_in  input  `InstTypeWidth  one of `LB, `LH, `LW, `LBU, `LHU
- lbuffer_rs_rdy_out  output  1  combinational; high when free entries are 2 or more
- lbuffer_mem_req_out  output  1  read request, registered, level
- lbuffer_mem_addr_out  output  `AddressWidth  read address, registered
- lbuffer_mem_size_out  output  2  0 = byte, 1 = half, 2 = word
- mem_lbuffer_valid_in  input  1  one-cycle pulse, read data valid
- mem_lbuffer_data_in  input  `IDWidth  read data, right-aligned
- lbuffer_cdb_b_out  output  `ROBWidth  broadcast tag, 0 = no broadcast
- lbuffer_cdb_result_out  output  `IDWidth  broadcast value

## Operation
- FIFO: head, tail, count (PTR_WIDTH+1 bits). Pointers wrap modulo DEPTH.
- Enqueue occurs when en is high, the opcode is a load, and count < DEPTH. Otherwise the request is dropped with no state change.
- FSM states: IDLE, WAIT, DRAIN.
- IDLE: if count > 0, register req=1, addr and size from the head entry, then go to WAIT.
- WAIT: hold req, addr and size steady. On valid:
  - clear req;
  - extend the data (LB: sign of bit 7; LBU: zero-extend [7:0]; LH: sign of bit 15; LHU: zero-extend [15:0]; LW: unchanged);
  - register cdb_b = head dest and cdb_result = extended data;
  - pop the head;
  - go to IDLE.
- DRAIN: entered on a flush while in WAIT (the memory controller cannot cancel). Req is already cleared. The next valid is discarded and the FSM goes to IDLE. New enqueues are accepted during DRAIN but are not issued until IDLE.
- Flush, priority over everything:
  - head, tail and count go to 0; cdb_b goes to 0; req goes to 0;
  - WAIT goes to DRAIN, all other states go to IDLE;
  - an enqueue in the same cycle is dropped.
- Reset values: FIFO empty, state IDLE, req 0, addr 0, size 0, cdb_b 0, cdb_result 0, so lbuffer_rs_rdy_out is 1.
- Size encoding: byte for LB/LBU, half for LH/LHU, word for LW.

## Timing
- Enqueue at edge N into an empty IDLE buffer: req is high after edge N+1.
- Valid at edge M: cdb_b/result are valid for exactly the cycle after edge M. cdb_b returns to 0 at edge M+1 unless a new broadcast is produced.
- Back-to-back loads: the next req rises at edge M+1 (IDLE re-issues). Minimum spacing is 2 cycles plus memory latency per load.
- The rdy threshold of 2 covers one load already released by the RS and in flight through the address unit.
- Enqueue and pop in the same edge: count is unchanged, both pointers advance.
- mem_lbuffer_valid_in is sampled only with rdy_in high. The controller shares rdy_in gating.
- Reset asserted mid-WAIT clears req immediately and goes to IDLE, not DRAIN. The controller is reset by the same signal.

## Test plan
- Reset, then enqueue LW addr 0x100 dest 3. Required: req=1, addr 0x100, size 2 one cycle later. Return valid with data 0xDEADBEEF. Required: cdb_b=3, result 0xDEADBEEF for exactly one cycle, then cdb_b=0.
- LB with data 0x80: result 0xFFFFFF80. LBU with 0x80: 0x00000080. LH with 0x8001: 0xFFFF8001. LHU with 0x8001: 0x00008001.
- Fill 4 loads with the memory stalled. Required: rdy drops after the 3rd enqueue, a 5th enqueue is ignored, the 4 results broadcast in enqueue order, and head/tail wrap correctly on a second fill.
- Flush during WAIT (dest 5 outstanding), enqueue LW dest 7 one cycle later, then return stale valid 0x11. Required: no broadcast of 0x11, then req for dest 7 and a broadcast of dest 7 only.
- Hold rdy_in low for 3 cycles while valid is pending. Required: all outputs frozen. Raise rdy_in. Required: normal completion.
- Assert rst_in asynchronously mid-WAIT. Required: all outputs 0 before the next clock edge, rdy=1.

Source files
------------

// File: rtl/load_buffer.sv
// Load execution unit: in-order FIFO of address-resolved loads, one outstanding
// memory read at a time, size-extended result broadcast on the load CDB lane.

`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef ROBWidth
`define ROBWidth 4
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef LB
`define LB 6'd11
`endif
`ifndef LH
`define LH 6'd12
`endif
`ifndef LW
`define LW 6'd13
`endif
`ifndef LBU
`define LBU 6'd14
`endif
`ifndef LHU
`define LHU 6'd15
`endif

module load_buffer #(
    parameter int DEPTH     = 4,
    parameter int PTR_WIDTH = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      rdy_in,
    input  logic                      rob_lbuffer_rst_in,
    input  logic                      addrunit_lbuffer_en_in,
    input  logic [`AddressWidth-1:0]  addrunit_lbuffer_addr_in,
    input  logic [`ROBWidth-1:0]      addrunit_lbuffer_dest_in,
    input  logic [`InstTypeWidth-1:0] addrunit_lbuffer_opcode_in,
    output logic                      lbuffer_rs_rdy_out,
    output logic                      lbuffer_mem_req_out,
    output logic [`AddressWidth-1:0]  lbuffer_mem_addr_out,
    output logic [1:0]                lbuffer_mem_size_out,
    input  logic                      mem_lbuffer_valid_in,
    input  logic [`IDWidth-1:0]       mem_lbuffer_data_in,
    output logic [`ROBWidth-1:0]      lbuffer_cdb_b_out,
    output logic [`IDWidth-1:0]       lbuffer_cdb_result_out
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    localparam logic [PTR_WIDTH:0]   CNT_FULL = (PTR_WIDTH+1)'(DEPTH);
    localparam logic [PTR_WIDTH:0]   CNT_ONE  = (PTR_WIDTH+1)'(1);
    localparam logic [PTR_WIDTH:0]   CNT_RDY  = (PTR_WIDTH+1)'(DEPTH - 2);
    localparam logic [PTR_WIDTH-1:0] PTR_ONE  = PTR_WIDTH'(1);

    logic [`AddressWidth-1:0]  r_addr_mem [DEPTH];
    logic [`ROBWidth-1:0]      r_dest_mem [DEPTH];
    logic [`InstTypeWidth-1:0] r_op_mem   [DEPTH];

    state_t                    r_state;
    logic [PTR_WIDTH-1:0]      r_head;
    logic [PTR_WIDTH-1:0]      r_tail;
    logic [PTR_WIDTH:0]        r_count;
    logic                      r_req;
    logic [`AddressWidth-1:0]  r_addr;
    logic [1:0]                r_size;
    logic [`ROBWidth-1:0]      r_cdb_b;
    logic [`IDWidth-1:0]       r_cdb_result;

    state_t                    w_state_next;
    logic [PTR_WIDTH-1:0]      w_head_next;
    logic [PTR_WIDTH-1:0]      w_tail_next;
    logic [PTR_WIDTH:0]        w_count_next;
    logic                      w_req_next;
    logic [`AddressWidth-1:0]  w_addr_next;
    logic [1:0]                w_size_next;
    logic [`ROBWidth-1:0]      w_cdb_b_next;
    logic [`IDWidth-1:0]       w_cdb_result_next;

    logic                      w_is_load;
    logic                      w_enq;
    logic                      w_pop;
    logic [`AddressWidth-1:0]  w_head_addr;
    logic [`ROBWidth-1:0]      w_head_dest;
    logic [`InstTypeWidth-1:0] w_head_op;

    function automatic logic [1:0] size_of(input logic [`InstTypeWidth-1:0] op);
        logic [1:0] s;
        s = 2'd2;
        if (op == `LB || op == `LBU)
            s = 2'd0;
        else if (op == `LH || op == `LHU)
            s = 2'd1;
        return s;
    endfunction

    function automatic logic [`IDWidth-1:0] extend(input logic [`InstTypeWidth-1:0] op,
                                                   input logic [`IDWidth-1:0] d);
        logic [`IDWidth-1:0] v;
        v = d;
        case (op)
            `LB:     v = {{(`IDWidth-8){d[7]}}, d[7:0]};
            `LBU:    v = {{(`IDWidth-8){1'b0}}, d[7:0]};
            `LH:     v = {{(`IDWidth-16){d[15]}}, d[15:0]};
            `LHU:    v = {{(`IDWidth-16){1'b0}}, d[15:0]};
            default: v = d;
        endcase
        return v;
    endfunction

    assign w_is_load = (addrunit_lbuffer_opcode_in == `LB)  || (addrunit_lbuffer_opcode_in == `LH)
                    || (addrunit_lbuffer_opcode_in == `LW)  || (addrunit_lbuffer_opcode_in == `LBU)
                    || (addrunit_lbuffer_opcode_in == `LHU);
    assign w_enq = addrunit_lbuffer_en_in && w_is_load && (r_count < CNT_FULL) && !rob_lbuffer_rst_in;

    assign w_head_addr = r_addr_mem[r_head];
    assign w_head_dest = r_dest_mem[r_head];
    assign w_head_op   = r_op_mem[r_head];

    // Two free slots: one for a load the RS may already have released upstream.
    assign lbuffer_rs_rdy_out     = (r_count <= CNT_RDY);
    assign lbuffer_mem_req_out    = r_req;
    assign lbuffer_mem_addr_out   = r_addr;
    assign lbuffer_mem_size_out   = r_size;
    assign lbuffer_cdb_b_out      = r_cdb_b;
    assign lbuffer_cdb_result_out = r_cdb_result;

    always_comb begin
        w_state_next      = r_state;
        w_req_next        = r_req;
        w_addr_next       = r_addr;
        w_size_next       = r_size;
        w_cdb_b_next      = '0;
        w_cdb_result_next = r_cdb_result;
        w_pop             = 1'b0;
        if (rob_lbuffer_rst_in) begin
            // A read already in flight cannot be cancelled, so its reply is drained.
            w_state_next = (r_state == S_WAIT) ? S_DRAIN : S_IDLE;
            w_req_next   = 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_count != '0) begin
                        w_req_next   = 1'b1;
                        w_addr_next  = w_head_addr;
                        w_size_next  = size_of(w_head_op);
                        w_state_next = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (mem_lbuffer_valid_in) begin
                        w_req_next        = 1'b0;
                        w_cdb_b_next      = w_head_dest;
                        w_cdb_result_next = extend(w_head_op, mem_lbuffer_data_in);
                        w_pop             = 1'b1;
                        w_state_next      = S_IDLE;
                    end
                end
                S_DRAIN: begin
                    if (mem_lbuffer_valid_in)
                        w_state_next = S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
    end

    always_comb begin
        w_head_next  = r_head;
        w_tail_next  = r_tail;
        w_count_next = r_count;
        if (rob_lbuffer_rst_in) begin
            w_head_next  = '0;
            w_tail_next  = '0;
            w_count_next = '0;
        end else begin
            if (w_enq)
                w_tail_next = r_tail + PTR_ONE;
            if (w_pop)
                w_head_next = r_head + PTR_ONE;
            if (w_enq && !w_pop)
                w_count_next = r_count + CNT_ONE;
            else if (!w_enq && w_pop)
                w_count_next = r_count - CNT_ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rdy_in && w_enq) begin
            r_addr_mem[r_tail] <= addrunit_lbuffer_addr_in;
            r_dest_mem[r_tail] <= addrunit_lbuffer_dest_in;
            r_op_mem[r_tail]   <= addrunit_lbuffer_opcode_in;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state      <= S_IDLE;
            r_head       <= '0;
            r_tail       <= '0;
            r_count      <= '0;
            r_req        <= 1'b0;
            r_addr       <= '0;
            r_size       <= '0;
            r_cdb_b      <= '0;
            r_cdb_result <= '0;
        end else if (rdy_in) begin
            r_state      <= w_state_next;
            r_head       <= w_head_next;
            r_tail       <= w_tail_next;
            r_count      <= w_count_next;
            r_req        <= w_req_next;
            r_addr       <= w_addr_next;
            r_size       <= w_size_next;
            r_cdb_b      <= w_cdb_b_next;
            r_cdb_result <= w_cdb_result_next;
        end
    end

endmodule

// File: tb/tb_load_buffer.sv
// Directed bench for load_buffer: expected broadcasts queued at enqueue time,
// popped and compared as the bench plays the memory controller.

`ifndef AddressWidth
`define AddressWidth 32
`endif
`ifndef ROBWidth
`define ROBWidth 4
`endif
`ifndef InstTypeWidth
`define InstTypeWidth 6
`endif
`ifndef IDWidth
`define IDWidth 32
`endif
`ifndef LB
`define LB 6'd11
`endif
`ifndef LH
`define LH 6'd12
`endif
`ifndef LW
`define LW 6'd13
`endif
`ifndef LBU
`define LBU 6'd14
`endif
`ifndef LHU
`define LHU 6'd15
`endif

module tb_load_buffer;

    logic                      clk_in = 1'b0;
    logic                      rst_in = 1'b1;
    logic                      rdy_in = 1'b1;
    logic                      flush = 1'b0;
    logic                      en = 1'b0;
    logic [`AddressWidth-1:0]  addr = '0;
    logic [`ROBWidth-1:0]      dest = '0;
    logic [`InstTypeWidth-1:0] op = '0;
    logic                      valid = 1'b0;
    logic [`IDWidth-1:0]       data = '0;
    logic                      rs_rdy;
    logic                      req;
    logic [`AddressWidth-1:0]  mem_addr;
    logic [1:0]                mem_size;
    logic [`ROBWidth-1:0]      cdb_b;
    logic [`IDWidth-1:0]       cdb_result;

    typedef struct {
        logic [`ROBWidth-1:0]     dest;
        logic [`AddressWidth-1:0] addr;
        logic [1:0]               size;
        logic [`IDWidth-1:0]      data;
        logic [`IDWidth-1:0]      result;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    load_buffer #(.DEPTH(4), .PTR_WIDTH(2)) dut (
        .clk_in                     (clk_in),
        .rst_in                     (rst_in),
        .rdy_in                     (rdy_in),
        .rob_lbuffer_rst_in         (flush),
        .addrunit_lbuffer_en_in     (en),
        .addrunit_lbuffer_addr_in   (addr),
        .addrunit_lbuffer_dest_in   (dest),
        .addrunit_lbuffer_opcode_in (op),
        .lbuffer_rs_rdy_out         (rs_rdy),
        .lbuffer_mem_req_out        (req),
        .lbuffer_mem_addr_out       (mem_addr),
        .lbuffer_mem_size_out       (mem_size),
        .mem_lbuffer_valid_in       (valid),
        .mem_lbuffer_data_in        (data),
        .lbuffer_cdb_b_out          (cdb_b),
        .lbuffer_cdb_result_out     (cdb_result)
    );

    always #5 clk_in = ~clk_in;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic enq(input logic [`InstTypeWidth-1:0] o, input logic [`AddressWidth-1:0] a,
                       input logic [`ROBWidth-1:0] d, input logic [`IDWidth-1:0] rd,
                       input logic [`IDWidth-1:0] res, input logic [1:0] sz, input bit accept);
        exp_t e;
        en = 1'b1; op = o; addr = a; dest = d;
        if (accept) begin
            e.dest = d; e.addr = a; e.size = sz; e.data = rd; e.result = res;
            sb.push_back(e);
        end
        @(negedge clk_in);
        en = 1'b0;
        $display("enq op=%0d addr=0x%0h dest=%0d accept=%0d", o, a, d, accept);
    endtask

    task automatic wait_req(input string tag);
        int n = 0;
        while (req !== 1'b1 && n < 30) begin
            @(negedge clk_in);
            n++;
        end
        check({tag, "_req_seen"}, req, 1);
    endtask

    task automatic serve(input int lat);
        exp_t e;
        wait_req("serve");
        if (sb.size() == 0) begin
            check("serve_scoreboard_nonempty", 0, 1);
            return;
        end
        e = sb.pop_front();
        check("serve_addr", mem_addr, e.addr);
        check("serve_size", mem_size, e.size);
        repeat (lat) @(negedge clk_in);
        check("serve_req_held", req, 1);
        valid = 1'b1; data = e.data;
        @(negedge clk_in);
        valid = 1'b0;
        check("serve_cdb_b", cdb_b, e.dest);
        check("serve_cdb_result", cdb_result, e.result);
        check("serve_req_cleared", req, 0);
        @(negedge clk_in);
        check("serve_cdb_b_idle", cdb_b, 0);
        $display("bcast dest=%0d result=0x%0h", e.dest, e.result);
    endtask

    initial begin
        // Reset values
        @(negedge clk_in);
        @(negedge clk_in);
        check("rst_req", req, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_size", mem_size, 0);
        check("rst_cdb_b", cdb_b, 0);
        check("rst_result", cdb_result, 0);
        check("rst_rdy", rs_rdy, 1);
        rst_in = 1'b0;
        @(negedge clk_in);

        // Single LW and issue latency
        enq(`LW, 32'h100, 4'd3, 32'hDEADBEEF, 32'hDEADBEEF, 2'd2, 1);
        check("lw_req_not_yet", req, 0);
        @(negedge clk_in);
        check("lw_req_latency", req, 1);
        serve(1);

        // Size extension
        enq(`LB,  32'h104, 4'd1, 32'h80, 32'hFFFFFF80, 2'd0, 1);
        serve(0);
        enq(`LBU, 32'h108, 4'd2, 32'h80, 32'h00000080, 2'd0, 1);
        serve(0);
        enq(`LH,  32'h10C, 4'd4, 32'h8001, 32'hFFFF8001, 2'd1, 1);
        serve(0);
        enq(`LHU, 32'h110, 4'd6, 32'h8001, 32'h00008001, 2'd1, 1);
        serve(0);

        // Non-load opcode is dropped
        enq(6'd0, 32'h114, 4'd2, 32'h0, 32'h0, 2'd0, 0);
        repeat (3) @(negedge clk_in);
        check("nonload_no_req", req, 0);
        check("nonload_rdy", rs_rdy, 1);

        // Fill twice with memory stalled; pointers wrap
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 4; i++) begin
                enq(`LW, 32'h200 + 32'(i * 4 + r * 64), 4'(8 + i), 32'h1000_0000 + 32'(i + r * 16),
                    32'h1000_0000 + 32'(i + r * 16), 2'd2, 1);
                check("fill_rdy", rs_rdy, (i < 2) ? 1 : 0);
            end
            enq(`LW, 32'h2F0, 4'd15, 32'h0, 32'h0, 2'd2, 0);
            check("fill_full_rdy", rs_rdy, 0);
            for (int i = 0; i < 4; i++)
                serve(1);
            check("fill_drained_rdy", rs_rdy, 1);
        end

        // Flush during WAIT: stale reply discarded
        enq(`LW, 32'h300, 4'd5, 32'h11, 32'h11, 2'd2, 0);
        wait_req("flush");
        flush = 1'b1;
        @(negedge clk_in);
        flush = 1'b0;
        check("flush_req", req, 0);
        check("flush_cdb_b", cdb_b, 0);
        enq(`LW, 32'h304, 4'd7, 32'h77, 32'h77, 2'd2, 1);
        check("drain_no_issue", req, 0);
        valid = 1'b1; data = 32'h11;
        @(negedge clk_in);
        valid = 1'b0;
        check("stale_no_bcast", cdb_b, 0);
        serve(1);

        // Global enable low freezes everything
        enq(`LW, 32'h400, 4'd9, 32'hCAFEF00D, 32'hCAFEF00D, 2'd2, 1);
        wait_req("stall");
        begin
            exp_t e;
            e = sb.pop_front();
            valid = 1'b1; data = e.data; rdy_in = 1'b0;
            repeat (3) begin
                @(negedge clk_in);
                check("stall_req", req, 1);
                check("stall_addr", mem_addr, e.addr);
                check("stall_cdb_b", cdb_b, 0);
                check("stall_result", cdb_result, 32'h77);
            end
            rdy_in = 1'b1;
            @(negedge clk_in);
            valid = 1'b0;
            check("unstall_cdb_b", cdb_b, e.dest);
            check("unstall_result", cdb_result, e.result);
            @(negedge clk_in);
            check("unstall_cdb_idle", cdb_b, 0);
            $display("bcast dest=%0d result=0x%0h", e.dest, e.result);
        end

        // Asynchronous reset mid-WAIT
        enq(`LW, 32'h500, 4'd10, 32'h1, 32'h1, 2'd2, 0);
        wait_req("arst");
        #2 rst_in = 1'b1;
        #1;
        check("arst_req", req, 0);
        check("arst_addr", mem_addr, 0);
        check("arst_size", mem_size, 0);
        check("arst_cdb_b", cdb_b, 0);
        check("arst_result", cdb_result, 0);
        check("arst_rdy", rs_rdy, 1);
        @(negedge clk_in);
        rst_in = 1'b0;
        repeat (2) @(negedge clk_in);
        check("arst_idle_empty", req, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
